// File: rtl/layer_pkg.sv
// Shared types and constants for the layer serializer slice.
//   serializer_state_e : FSM states of the serializer.
//   GAP_W              : width of the inter-frame gap counter.
//   DEFAULT_DATA_WIDTH : default element width of the layer datapath.
package layer_pkg;

  typedef enum logic [1:0] {
    IDLE,
    STREAM,
    GAP
  } serializer_state_e;

  localparam int unsigned GAP_W = 4;
  localparam int unsigned DEFAULT_DATA_WIDTH = 24;

endpackage

// File: rtl/layer_serializer_if.sv
// Bus between an upstream layer (parallel vector) and the serializer that
// feeds a downstream layer (serial stream).
//   i_valid    : single-cycle pulse, din holds a complete vector
//   din        : NUM_NODES x DATA_WIDTH parallel vector
//   dout       : current serial element, 0 when o_valid is low
//   o_start    : high with element 0 only
//   o_valid    : high for every element cycle
//   o_last     : high with element NUM_NODES-1
//   o_busy     : serializer not idle or pending bank full
//   o_overflow : sticky, a vector was dropped
// master = upstream/observer side, slave = serializer side.
interface layer_serializer_if
  import layer_pkg::*;
#(
  parameter int unsigned DATA_WIDTH = DEFAULT_DATA_WIDTH,
  parameter int unsigned NUM_NODES  = 500
);

  logic                  i_valid;
  logic [DATA_WIDTH-1:0] din [NUM_NODES];
  logic [DATA_WIDTH-1:0] dout;
  logic                  o_start;
  logic                  o_valid;
  logic                  o_last;
  logic                  o_busy;
  logic                  o_overflow;

  modport master (
    output i_valid, din,
    input  dout, o_start, o_valid, o_last, o_busy, o_overflow
  );

  modport slave (
    input  i_valid, din,
    output dout, o_start, o_valid, o_last, o_busy, o_overflow
  );

endinterface

// File: rtl/vec_bank.sv
// NUM_NODES x DATA_WIDTH register bank with whole-vector load and an indexed
// combinational read. The full contents are also exposed for bank-to-bank
// transfer.
//   clk       : clock
//   load_i    : load vec_i into the bank this cycle
//   vec_i     : vector to load
//   rd_idx_i  : read index (kept below NUM_NODES by the caller)
//   rd_data_o : element at rd_idx_i
//   vec_o     : whole stored vector
module vec_bank
  import layer_pkg::*;
#(
  parameter int unsigned DATA_WIDTH = DEFAULT_DATA_WIDTH,
  parameter int unsigned NUM_NODES  = 500,
  localparam int unsigned IDX_W     = $clog2(NUM_NODES)
) (
  input  logic                  clk,
  input  logic                  load_i,
  input  logic [DATA_WIDTH-1:0] vec_i [NUM_NODES],
  input  logic [IDX_W-1:0]      rd_idx_i,
  output logic [DATA_WIDTH-1:0] rd_data_o,
  output logic [DATA_WIDTH-1:0] vec_o [NUM_NODES]
);

  logic [DATA_WIDTH-1:0] mem_q [NUM_NODES];

  // Pure datapath storage: contents are only meaningful once loaded.
  always_ff @(posedge clk) begin
    if (load_i) begin
      mem_q <= vec_i;
    end
  end

  assign rd_data_o = mem_q[rd_idx_i];
  assign vec_o     = mem_q;

endmodule

// File: rtl/layer_serializer.sv
// Parallel-to-serial converter between network layers. A full vector is
// captured on i_valid and streamed one element per cycle with a start pulse,
// double-buffered (active + pending bank), with MIN_GAP idle cycles forced
// between frames.
//   clk, rst : clock, synchronous active-high reset
//   bus      : layer_serializer_if slave modport (see interface header)
// Optional: define LAYER_SERIALIZER_RELU_EN to clamp negative elements to 0
// on the read path.
module layer_serializer
  import layer_pkg::*;
#(
  parameter int unsigned DATA_WIDTH = DEFAULT_DATA_WIDTH,
  parameter int unsigned NUM_NODES  = 500,
  parameter int unsigned MIN_GAP    = 1
) (
  input logic               clk,
  input logic               rst,
  layer_serializer_if.slave bus
);

  localparam int unsigned       IDX_W    = $clog2(NUM_NODES);
  localparam logic [IDX_W-1:0]  LAST_IDX = IDX_W'(NUM_NODES - 1);
  localparam logic [GAP_W-1:0]  GAP_INIT = (MIN_GAP > 0) ? GAP_W'(MIN_GAP - 1) : '0;

  serializer_state_e     state_q, state_d;
  logic [IDX_W-1:0]      idx_q, idx_d;
  logic [GAP_W-1:0]      gap_q, gap_d;
  logic                  pend_full_q, pend_full_d;
  logic                  ovf_q, ovf_d;
  logic [DATA_WIDTH-1:0] dout_q, dout_d;
  logic                  start_q, start_d;
  logic                  valid_q, valid_d;
  logic                  last_q, last_d;

  logic                  begin_frame;
  logic                  drain;
  logic                  act_load;
  logic                  pend_load;
  logic [DATA_WIDTH-1:0] act_vec_in [NUM_NODES];
  logic [DATA_WIDTH-1:0] pend_vec [NUM_NODES];
  logic [DATA_WIDTH-1:0] active_vec_unused [NUM_NODES];
  logic [DATA_WIDTH-1:0] act_rd_data;
  logic [DATA_WIDTH-1:0] pend_rd_data;
  logic [DATA_WIDTH-1:0] raw_elem;

  // Active bank loads from din on a fresh start, or from pending on a drain.
  always_comb begin
    for (int i = 0; i < int'(NUM_NODES); i++) begin
      act_vec_in[i] = drain ? pend_vec[i] : bus.din[i];
    end
  end

  vec_bank #(
    .DATA_WIDTH (DATA_WIDTH),
    .NUM_NODES  (NUM_NODES)
  ) u_active (
    .clk       (clk),
    .load_i    (act_load),
    .vec_i     (act_vec_in),
    .rd_idx_i  (idx_d),
    .rd_data_o (act_rd_data),
    .vec_o     (active_vec_unused)
  );

  vec_bank #(
    .DATA_WIDTH (DATA_WIDTH),
    .NUM_NODES  (NUM_NODES)
  ) u_pending (
    .clk       (clk),
    .load_i    (pend_load),
    .vec_i     (bus.din),
    .rd_idx_i  ('0),
    .rd_data_o (pend_rd_data),
    .vec_o     (pend_vec)
  );

  // Next-state logic. state_q/idx_q describe the element on the outputs now;
  // the *_d values describe the element registered for the next cycle.
  always_comb begin
    state_d     = state_q;
    idx_d       = idx_q;
    gap_d       = gap_q;
    pend_full_d = pend_full_q;
    ovf_d       = ovf_q;
    start_d     = 1'b0;
    valid_d     = 1'b0;
    last_d      = 1'b0;
    begin_frame = 1'b0;
    drain       = 1'b0;
    act_load    = 1'b0;
    pend_load   = 1'b0;

    unique case (state_q)
      IDLE: begin
        // A vector captured into pending on the cycle we fell back to IDLE
        // is started here rather than stranded.
        if (pend_full_q) begin
          drain       = 1'b1;
          begin_frame = 1'b1;
        end else if (bus.i_valid) begin
          act_load    = 1'b1;
          begin_frame = 1'b1;
        end
      end
      STREAM: begin
        if (idx_q == LAST_IDX) begin
          if (MIN_GAP != 0) begin
            state_d = GAP;
            gap_d   = GAP_INIT;
          end else if (pend_full_q) begin
            drain       = 1'b1;
            begin_frame = 1'b1;
          end else begin
            state_d = IDLE;
          end
        end else begin
          idx_d   = idx_q + 1'b1;
          valid_d = 1'b1;
          last_d  = (idx_d == LAST_IDX);
        end
      end
      GAP: begin
        if (gap_q == '0) begin
          if (pend_full_q) begin
            drain       = 1'b1;
            begin_frame = 1'b1;
          end else begin
            state_d = IDLE;
          end
        end else begin
          gap_d = gap_q - 1'b1;
        end
      end
      default: state_d = IDLE;
    endcase

    if (drain) begin
      act_load = 1'b1;
    end

    if (begin_frame) begin
      state_d = STREAM;
      idx_d   = '0;
      start_d = 1'b1;
      valid_d = 1'b1;
    end

    // Any i_valid not taken straight into the active bank goes to pending;
    // a pending bank that drains this cycle counts as free.
    if (bus.i_valid && !(act_load && !drain)) begin
      if (!pend_full_q || drain) begin
        pend_load = 1'b1;
      end else begin
        ovf_d = 1'b1;
      end
    end

    if (pend_load) begin
      pend_full_d = 1'b1;
    end else if (drain) begin
      pend_full_d = 1'b0;
    end
  end

  // Element source for the next cycle: din on a fresh start, pending on a
  // drain, otherwise the active bank at the next index.
  always_comb begin
    if (act_load && !drain) begin
      raw_elem = bus.din[0];
    end else if (drain) begin
      raw_elem = pend_rd_data;
    end else begin
      raw_elem = act_rd_data;
    end

    if (!valid_d) begin
      dout_d = '0;
    end else begin
`ifdef LAYER_SERIALIZER_RELU_EN
      dout_d = raw_elem[DATA_WIDTH-1] ? '0 : raw_elem;
`else
      dout_d = raw_elem;
`endif
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q     <= IDLE;
      idx_q       <= '0;
      gap_q       <= '0;
      pend_full_q <= 1'b0;
      ovf_q       <= 1'b0;
      dout_q      <= '0;
      start_q     <= 1'b0;
      valid_q     <= 1'b0;
      last_q      <= 1'b0;
    end else begin
      state_q     <= state_d;
      idx_q       <= idx_d;
      gap_q       <= gap_d;
      pend_full_q <= pend_full_d;
      ovf_q       <= ovf_d;
      dout_q      <= dout_d;
      start_q     <= start_d;
      valid_q     <= valid_d;
      last_q      <= last_d;
    end
  end

  assign bus.dout       = dout_q;
  assign bus.o_start    = start_q;
  assign bus.o_valid    = valid_q;
  assign bus.o_last     = last_q;
  assign bus.o_busy     = (state_q != IDLE) || pend_full_q;
  assign bus.o_overflow = ovf_q;

endmodule

// File: tb/tb_layer_serializer.sv
// Bench for layer_serializer: NUM_NODES=4, DATA_WIDTH=8. DUT A uses MIN_GAP=1,
// DUT B uses MIN_GAP=0. Each table row drives one cycle of inputs and lists
// the outputs expected right after the following rising edge.
module tb_layer_serializer;

  localparam int unsigned DW = 8;
  localparam int unsigned NN = 4;

  logic clk = 1'b0;
  logic rst = 1'b1;

  always #5 clk = ~clk;

  layer_serializer_if #(.DATA_WIDTH(DW), .NUM_NODES(NN)) ifa ();
  layer_serializer_if #(.DATA_WIDTH(DW), .NUM_NODES(NN)) ifb ();

  layer_serializer #(
    .DATA_WIDTH (DW),
    .NUM_NODES  (NN),
    .MIN_GAP    (1)
  ) u_dut_a (
    .clk (clk),
    .rst (rst),
    .bus (ifa)
  );

  layer_serializer #(
    .DATA_WIDTH (DW),
    .NUM_NODES  (NN),
    .MIN_GAP    (0)
  ) u_dut_b (
    .clk (clk),
    .rst (rst),
    .bus (ifb)
  );

  typedef struct {
    bit              sel;    // 0: DUT A, 1: DUT B
    bit              rst;
    bit              iv;
    logic [3:0][7:0] din;    // din[0] is element 0
    logic [7:0]      dout;
    bit              start;
    bit              valid;
    bit              last;
    bit              busy;
    bit              ovf;
  } vec_t;

  vec_t tbl[$];
  int   n_tests = 0;
  int   n_fail  = 0;

  function automatic logic [31:0] pk(input logic [7:0] e0, e1, e2, e3);
    return {e3, e2, e1, e0};
  endfunction

  function automatic logic [7:0] relu8(input logic [7:0] x);
`ifdef LAYER_SERIALIZER_RELU_EN
    return x[7] ? 8'h00 : x;
`else
    return x;
`endif
  endfunction

  // add(sel, rst, iv, din, dout, start, valid, last, busy, ovf)
  function automatic void add(input bit sel, r, iv, input logic [31:0] d,
                              input logic [7:0] dout, input bit st, va, la, bu, ov);
    vec_t v;
    v.sel = sel; v.rst = r; v.iv = iv; v.din = d;
    v.dout = dout; v.start = st; v.valid = va; v.last = la; v.busy = bu; v.ovf = ov;
    tbl.push_back(v);
  endfunction

  function automatic logic [12:0] outs(input bit sel);
    if (sel) return {ifb.dout, ifb.o_start, ifb.o_valid, ifb.o_last, ifb.o_busy, ifb.o_overflow};
    return {ifa.dout, ifa.o_start, ifa.o_valid, ifa.o_last, ifa.o_busy, ifa.o_overflow};
  endfunction

  task automatic apply(input vec_t v, input int n);
    logic [12:0] got, exp;
    rst         = v.rst;
    ifa.i_valid = 1'b0;
    ifb.i_valid = 1'b0;
    for (int k = 0; k < 4; k++) begin
      if (v.sel) ifb.din[k] = v.din[k];
      else       ifa.din[k] = v.din[k];
    end
    if (v.sel) ifb.i_valid = v.iv;
    else       ifa.i_valid = v.iv;
    @(posedge clk);
    #1;
    got = outs(v.sel);
    exp = {v.dout, v.start, v.valid, v.last, v.busy, v.ovf};
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL vec%0d dut%s: got dout=%h st=%b va=%b la=%b busy=%b ovf=%b, want dout=%h st=%b va=%b la=%b busy=%b ovf=%b",
               n, v.sel ? "B" : "A", got[12:5], got[4], got[3], got[2], got[1], got[0],
               exp[12:5], exp[4], exp[3], exp[2], exp[1], exp[0]);
    end
  endtask

  task automatic check(input string name, input int got, input int exp);
    n_tests++;
    if (got != exp) begin
      n_fail++;
      $display("FAIL %s: got %0d, want %0d", name, got, exp);
    end
  endtask

  initial begin
    logic [31:0] z;
    logic [31:0] fa, fb, fc, fr;
    int          cnt, sum;
    bit          done;
    z = '0;

    // ---- Test 1: single frame ----
    fa = pk(10, 20, 30, 40);
    add(0, 0, 1, fa, 10, 1, 1, 0, 1, 0);
    add(0, 0, 0, z,  20, 0, 1, 0, 1, 0);
    add(0, 0, 0, z,  30, 0, 1, 0, 1, 0);
    add(0, 0, 0, z,  40, 0, 1, 1, 1, 0);
    add(0, 0, 0, z,   0, 0, 0, 0, 1, 0);  // gap
    add(0, 0, 0, z,   0, 0, 0, 0, 0, 0);  // idle
    // ---- Test 2: second vector at T+2 held pending, 1-cycle gap ----
    fb = pk(1, 2, 3, 4);
    add(0, 0, 1, fa, 10, 1, 1, 0, 1, 0);
    add(0, 0, 0, z,  20, 0, 1, 0, 1, 0);
    add(0, 0, 1, fb, 30, 0, 1, 0, 1, 0);
    add(0, 0, 0, z,  40, 0, 1, 1, 1, 0);
    add(0, 0, 0, z,   0, 0, 0, 0, 1, 0);
    add(0, 0, 0, z,   1, 1, 1, 0, 1, 0);
    add(0, 0, 0, z,   2, 0, 1, 0, 1, 0);
    add(0, 0, 0, z,   3, 0, 1, 0, 1, 0);
    add(0, 0, 0, z,   4, 0, 1, 1, 1, 0);
    add(0, 0, 0, z,   0, 0, 0, 0, 1, 0);
    add(0, 0, 0, z,   0, 0, 0, 0, 0, 0);
    // ---- Test 3: three back-to-back pulses, third dropped ----
    add(0, 0, 1, pk(5, 6, 7, 8),     5, 1, 1, 0, 1, 0);
    add(0, 0, 1, pk(9, 10, 11, 12),  6, 0, 1, 0, 1, 0);
    add(0, 0, 1, pk(13, 14, 15, 16), 7, 0, 1, 0, 1, 1);
    add(0, 0, 0, z,  8, 0, 1, 1, 1, 1);
    add(0, 0, 0, z,  0, 0, 0, 0, 1, 1);
    add(0, 0, 0, z,  9, 1, 1, 0, 1, 1);
    add(0, 0, 0, z, 10, 0, 1, 0, 1, 1);
    add(0, 0, 0, z, 11, 0, 1, 0, 1, 1);
    add(0, 0, 0, z, 12, 0, 1, 1, 1, 1);
    add(0, 0, 0, z,  0, 0, 0, 0, 1, 1);
    add(0, 0, 0, z,  0, 0, 0, 0, 0, 1);
    add(0, 0, 0, z,  0, 0, 0, 0, 0, 1);   // no third frame
    // ---- Test 4: reset mid-frame drops pending and clears overflow ----
    add(0, 0, 1, fb,             1, 1, 1, 0, 1, 1);
    add(0, 0, 1, pk(5, 6, 7, 8), 2, 0, 1, 0, 1, 1);
    add(0, 1, 0, z,  0, 0, 0, 0, 0, 0);
    add(0, 0, 0, z,  0, 0, 0, 0, 0, 0);
    add(0, 0, 1, pk(21, 22, 23, 24), 21, 1, 1, 0, 1, 0);
    add(0, 0, 0, z, 22, 0, 1, 0, 1, 0);
    add(0, 0, 0, z, 23, 0, 1, 0, 1, 0);
    add(0, 0, 0, z, 24, 0, 1, 1, 1, 0);
    add(0, 0, 0, z,  0, 0, 0, 0, 1, 0);
    add(0, 0, 0, z,  0, 0, 0, 0, 0, 0);
    add(0, 0, 0, z,  0, 0, 0, 0, 0, 0);
    // ---- Test 5: MIN_GAP=0, no bubble; vector on last cycle accepted ----
    fc = pk(9, 10, 11, 12);
    add(1, 0, 1, fb,             1, 1, 1, 0, 1, 0);
    add(1, 0, 1, pk(5, 6, 7, 8), 2, 0, 1, 0, 1, 0);
    add(1, 0, 0, z,   3, 0, 1, 0, 1, 0);
    add(1, 0, 0, z,   4, 0, 1, 1, 1, 0);
    add(1, 0, 1, fc,  5, 1, 1, 0, 1, 0);
    add(1, 0, 0, z,   6, 0, 1, 0, 1, 0);
    add(1, 0, 0, z,   7, 0, 1, 0, 1, 0);
    add(1, 0, 0, z,   8, 0, 1, 1, 1, 0);
    add(1, 0, 0, z,   9, 1, 1, 0, 1, 0);
    add(1, 0, 0, z,  10, 0, 1, 0, 1, 0);
    add(1, 0, 0, z,  11, 0, 1, 0, 1, 0);
    add(1, 0, 0, z,  12, 0, 1, 1, 1, 0);
    add(1, 0, 0, z,   0, 0, 0, 0, 0, 0);
    // ---- Vector on the last GAP cycle with pending full is accepted ----
    add(0, 0, 1, fb,             1, 1, 1, 0, 1, 0);
    add(0, 0, 1, pk(5, 6, 7, 8), 2, 0, 1, 0, 1, 0);
    add(0, 0, 0, z,   3, 0, 1, 0, 1, 0);
    add(0, 0, 0, z,   4, 0, 1, 1, 1, 0);
    add(0, 0, 0, z,   0, 0, 0, 0, 1, 0);
    add(0, 0, 1, fc,  5, 1, 1, 0, 1, 0);
    add(0, 0, 0, z,   6, 0, 1, 0, 1, 0);
    add(0, 0, 0, z,   7, 0, 1, 0, 1, 0);
    add(0, 0, 0, z,   8, 0, 1, 1, 1, 0);
    add(0, 0, 0, z,   0, 0, 0, 0, 1, 0);
    add(0, 0, 0, z,   9, 1, 1, 0, 1, 0);
    add(0, 0, 0, z,  10, 0, 1, 0, 1, 0);
    add(0, 0, 0, z,  11, 0, 1, 0, 1, 0);
    add(0, 0, 0, z,  12, 0, 1, 1, 1, 0);
    add(0, 0, 0, z,   0, 0, 0, 0, 1, 0);
    add(0, 0, 0, z,   0, 0, 0, 0, 0, 0);
    // ---- Test 6: negative elements (clamped only with the ReLU option) ----
    fr = pk(8'hF0, 8'h05, 8'h80, 8'h7F);
    add(0, 0, 1, fr, relu8(8'hF0), 1, 1, 0, 1, 0);
    add(0, 0, 0, z,  relu8(8'h05), 0, 1, 0, 1, 0);
    add(0, 0, 0, z,  relu8(8'h80), 0, 1, 0, 1, 0);
    add(0, 0, 0, z,  relu8(8'h7F), 0, 1, 1, 1, 0);
    add(0, 0, 0, z,  0, 0, 0, 0, 1, 0);
    add(0, 0, 0, z,  0, 0, 0, 0, 0, 0);

    // ---- Reset state ----
    ifa.i_valid = 1'b0;
    ifb.i_valid = 1'b0;
    for (int k = 0; k < 4; k++) begin
      ifa.din[k] = '0;
      ifb.din[k] = '0;
    end
    rst = 1'b1;
    repeat (2) @(posedge clk);
    #1;
    check("reset_outputs_a", int'(outs(0)), 0);
    check("reset_outputs_b", int'(outs(1)), 0);
    rst = 1'b0;

    for (int i = 0; i < tbl.size(); i++) begin
      apply(tbl[i], i);
    end
    rst         = 1'b0;
    ifa.i_valid = 1'b0;
    ifb.i_valid = 1'b0;

    // ---- Bounded wait for a full frame on DUT A ----
    ifa.din[0] = 8'd2; ifa.din[1] = 8'd4; ifa.din[2] = 8'd6; ifa.din[3] = 8'd8;
    ifa.i_valid = 1'b1;
    cnt  = 0;
    sum  = 0;
    done = 1'b0;
    for (int c = 0; c < 20 && !done; c++) begin
      @(posedge clk);
      #1;
      ifa.i_valid = 1'b0;
      if (ifa.o_valid) begin
        cnt++;
        sum += int'(ifa.dout);
      end
      if (ifa.o_last) done = 1'b1;
    end
    check("frame_last_seen", int'(done), 1);
    check("frame_elem_count", cnt, 4);
    check("frame_elem_sum", sum, 20);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
